dut_chain_emulator: RTL

- Synthesizable FPGA-side model of the CMS pix28 DUT configuration and scan chains.
- Pins are looped back or the block replaces the ASIC, so fw_ip1/fw_ip2 firmwares are exercised end to end without silicon.
- Consumes the DUT-facing outputs of the fw-to-DUT mux/IOB block: reset_not, config_clk/in/load, bxclk, scan_in/load.
- Produces the DUT-side inputs: config_out, scan_out, scan_out_test, dn/up_event_toggle.

---
 rtl/cms_pix28_package.sv | 8 +
 rtl/com_edge_detect.sv | 44 ++++
 rtl/dut_chain_emulator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cms_pix28_package.sv
// Shared constants for the CMS pix28 DUT emulation blocks.
package cms_pix28_package;

  localparam int unsigned CFG_CHAIN_LEN  = 64;
  localparam int unsigned SCAN_CHAIN_LEN = 48;
  localparam int unsigned CHAIN_CNT_W    = 11;

endpackage

// File: rtl/com_edge_detect.sv
// Two-register sampler for an asynchronous pin with registered rise/fall pulses.
module com_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic smp_q;
  logic smp_qq;
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;

  always_comb begin
    rise_d = smp_q & ~smp_qq;
    fall_d = ~smp_q & smp_qq;
  end

  // Reset to the pin's idle level so releasing reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_q  <= RESET_VAL;
      smp_qq <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      smp_q  <= din;
      smp_qq <= smp_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = smp_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/dut_chain_emulator.sv
// FPGA-side stand-in for the pix28 configuration and scan shift chains.
module dut_chain_emulator
  import cms_pix28_package::*;
#(
  parameter int unsigned CFG_LEN  = CFG_CHAIN_LEN,
  parameter int unsigned SCAN_LEN = SCAN_CHAIN_LEN,
  parameter int unsigned CNT_W    = CHAIN_CNT_W
) (
  input  logic                iob_clk,
  input  logic                reset,
  input  logic                reset_not,
  input  logic                config_clk,
  input  logic                config_in,
  input  logic                config_load,
  input  logic                bxclk,
  input  logic                scan_in,
  input  logic                scan_load,
  input  logic [SCAN_LEN-1:0] scan_capture_data,
  output logic                config_out,
  output logic                scan_out,
  output logic                scan_out_test,
  output logic                dn_event_toggle,
  output logic                up_event_toggle,
  output logic [CFG_LEN-1:0]  cfg_shadow,
  output logic                cfg_len_err,
  output logic [CNT_W-1:0]    scan_shift_cnt
);

  logic rst_not_q;
  logic cfg_clk_rise;
  logic cfg_in_q;
  logic cfg_load_rise;
  logic bx_rise;
  logic scan_in_q;
  logic scan_load_q;
  logic [13:0] edge_unused;

  com_edge_detect #(.RESET_VAL(1'b1)) u_reset_not (
    .clk(iob_clk), .reset(reset), .din(reset_not),
    .q(rst_not_q), .rise(edge_unused[0]), .fall(edge_unused[1]));
  com_edge_detect #(.RESET_VAL(1'b0)) u_config_clk (
    .clk(iob_clk), .reset(reset), .din(config_clk),
    .q(edge_unused[2]), .rise(cfg_clk_rise), .fall(edge_unused[3]));
  com_edge_detect #(.RESET_VAL(1'b0)) u_config_in (
    .clk(iob_clk), .reset(reset), .din(config_in),
    .q(cfg_in_q), .rise(edge_unused[4]), .fall(edge_unused[5]));
  com_edge_detect #(.RESET_VAL(1'b1)) u_config_load (
    .clk(iob_clk), .reset(reset), .din(config_load),
    .q(edge_unused[6]), .rise(cfg_load_rise), .fall(edge_unused[7]));
  com_edge_detect #(.RESET_VAL(1'b0)) u_bxclk (
    .clk(iob_clk), .reset(reset), .din(bxclk),
    .q(edge_unused[8]), .rise(bx_rise), .fall(edge_unused[9]));
  com_edge_detect #(.RESET_VAL(1'b0)) u_scan_in (
    .clk(iob_clk), .reset(reset), .din(scan_in),
    .q(scan_in_q), .rise(edge_unused[10]), .fall(edge_unused[11]));
  com_edge_detect #(.RESET_VAL(1'b0)) u_scan_load (
    .clk(iob_clk), .reset(reset), .din(scan_load),
    .q(scan_load_q), .rise(edge_unused[12]), .fall(edge_unused[13]));

  logic [CFG_LEN-1:0]  cfg_sr_q,     cfg_sr_d;
  logic [CNT_W-1:0]    cfg_cnt_q,    cfg_cnt_d;
  logic [CFG_LEN-1:0]  cfg_shadow_q, cfg_shadow_d;
  logic                cfg_err_q,    cfg_err_d;
  logic                dn_tgl_q,     dn_tgl_d;
  logic [SCAN_LEN-1:0] scan_sr_q,    scan_sr_d;
  logic [CNT_W-1:0]    scan_cnt_q,   scan_cnt_d;
  logic                up_tgl_q,     up_tgl_d;
  logic                sot_q,        sot_d;

  always_comb begin
    cfg_sr_d     = cfg_sr_q;
    cfg_cnt_d    = cfg_cnt_q;
    cfg_shadow_d = cfg_shadow_q;
    cfg_err_d    = cfg_err_q;
    dn_tgl_d     = dn_tgl_q;
    scan_sr_d    = scan_sr_q;
    scan_cnt_d   = scan_cnt_q;
    up_tgl_d     = up_tgl_q;
    sot_d        = sot_q;
    // Chip reset wins over every chain event; toggles and retimed scan_in just hold.
    if (!rst_not_q) begin
      cfg_sr_d     = '0;
      cfg_cnt_d    = '0;
      cfg_shadow_d = '0;
      cfg_err_d    = 1'b0;
      scan_sr_d    = '0;
      scan_cnt_d   = '0;
    end else begin
      if (cfg_load_rise) begin
        cfg_shadow_d = cfg_sr_q;
        dn_tgl_d     = ~dn_tgl_q;
        cfg_cnt_d    = '0;
        if (cfg_cnt_q != CNT_W'(CFG_LEN)) cfg_err_d = 1'b1;
      end
      if (cfg_clk_rise) begin
        cfg_sr_d = {cfg_sr_q[CFG_LEN-2:0], cfg_in_q};
        if (cfg_load_rise)       cfg_cnt_d = CNT_W'(1);
        else if (cfg_cnt_q != '1) cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
      end
      if (bx_rise) begin
        sot_d = scan_in_q;
        if (scan_load_q) begin
          scan_sr_d  = scan_capture_data;
          up_tgl_d   = ~up_tgl_q;
          scan_cnt_d = '0;
        end else begin
          scan_sr_d = {scan_sr_q[SCAN_LEN-2:0], scan_in_q};
          if (scan_cnt_q != '1) scan_cnt_d = scan_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge iob_clk or posedge reset) begin
    if (reset) begin
      cfg_sr_q     <= '0;
      cfg_cnt_q    <= '0;
      cfg_shadow_q <= '0;
      cfg_err_q    <= 1'b0;
      dn_tgl_q     <= 1'b0;
      scan_sr_q    <= '0;
      scan_cnt_q   <= '0;
      up_tgl_q     <= 1'b0;
      sot_q        <= 1'b0;
    end else begin
      cfg_sr_q     <= cfg_sr_d;
      cfg_cnt_q    <= cfg_cnt_d;
      cfg_shadow_q <= cfg_shadow_d;
      cfg_err_q    <= cfg_err_d;
      dn_tgl_q     <= dn_tgl_d;
      scan_sr_q    <= scan_sr_d;
      scan_cnt_q   <= scan_cnt_d;
      up_tgl_q     <= up_tgl_d;
      sot_q        <= sot_d;
    end
  end

  assign config_out      = cfg_sr_q[CFG_LEN-1];
  assign scan_out        = scan_sr_q[SCAN_LEN-1];
  assign scan_out_test   = sot_q;
  assign dn_event_toggle = dn_tgl_q;
  assign up_event_toggle = up_tgl_q;
  assign cfg_shadow      = cfg_shadow_q;
  assign cfg_len_err     = cfg_err_q;
  assign scan_shift_cnt  = scan_cnt_q;

endmodule
